// File: rtl/point_stream_parser.sv
// point_stream_parser: assembles big-endian point words from UART bytes, buffers them, issues draw/jump commands.
// Optional macro BYTE_TIMEOUT_EN: abandons a partial word after TIMEOUT_CYCLES idle cycles.
module point_stream_parser #(
    parameter int DEPTH_LOG2     = 6,
    parameter int COORD_W        = 12,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_byte,
    input  logic                ready,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic                draw,
    output logic                jump,
    output logic                frame_active,
    output logic                overflow,
    output logic [DEPTH_LOG2:0] fifo_level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int EW    = 2 * COORD_W + 1;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [23:0]           word_q, word_d;
    logic [31:0]           nw;
    logic                  push_try, push, pop, full, abort;
    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         head;
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  issued_q, overflow_q, draw_q, jump_q;
    logic [COORD_W-1:0]    x_q, y_q;

`ifdef BYTE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_run;
    assign tmo_run = (state_q == FRAME) && (cnt_q != 2'd0) && !rx_valid;
    assign abort   = tmo_run && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    // Count idle cycles while a word is partially assembled; any byte restarts it
    always_ff @(posedge clk)
        tmo_q <= (reset || !tmo_run) ? '0 : tmo_q + TW'(1);
`else
    assign abort = 1'b0;
`endif

    assign nw   = {word_q, rx_byte};
    assign full = level_q == (DEPTH_LOG2 + 1)'(DEPTH);
    assign push = push_try && !full;
    assign pop  = ready && (level_q != '0) && !issued_q;
    assign head = mem[rd_q];

    // Parser next state: frame start filtering, byte shifting and word decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        push_try = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else if (rx_valid) begin
            if (state_q == IDLE) begin
                if (rx_byte != 8'h00) begin
                    state_d = FRAME;
                    cnt_d   = 2'd1;
                    word_d  = {16'h0, rx_byte};
                end
            end else begin
                word_d = nw[23:0];
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    if (nw == 32'h0101_0101) state_d = IDLE;
                    else push_try = 1'b1;
                end
            end
        end
    end

    // Point storage; stale entries are harmless since the pointers define validity
    always_ff @(posedge clk)
        if (push) mem[wr_q] <= nw[EW-1:0];

    // Parser state, FIFO bookkeeping and registered command outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            word_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            issued_q   <= 1'b0;
            draw_q     <= 1'b0;
            jump_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            wr_q       <= wr_q + DEPTH_LOG2'(push);
            rd_q       <= rd_q + DEPTH_LOG2'(pop);
            level_q    <= level_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
            overflow_q <= overflow_q | (push_try & full);
            issued_q   <= pop;
            draw_q     <= pop & head[EW-1];
            jump_q     <= pop & ~head[EW-1];
            if (pop) begin
                x_q <= head[2*COORD_W-1:COORD_W];
                y_q <= head[COORD_W-1:0];
            end
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign draw         = draw_q;
    assign jump         = jump_q;
    assign frame_active = state_q == FRAME;
    assign overflow     = overflow_q;
    assign fifo_level   = level_q;
endmodule
